// File: rtl/scanner_pkg.sv
// Purpose: shared types and ZBT0 word layout for the scanner front end and the renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scanner_pkg;

  localparam int COORD_W = 10;
  localparam int ZBT_AW  = 19;
  localparam int ZBT_DW  = 36;

  // Field offsets inside a ZBT0 word; the renderer unpacks with the same values.
  localparam int X_LSB = 20;
  localparam int Y_LSB = 10;
  localparam int Z_LSB = 0;

  // End-of-frame marker: bit 35 set, never produced by a data word.
  localparam logic [ZBT_DW-1:0] TERMINATOR = 36'h8_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pw_state_t;

  function automatic logic [ZBT_DW-1:0] pack_point(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [COORD_W-1:0] z
  );
    logic [ZBT_DW-1:0] w;
    w = '0;
    w[X_LSB +: COORD_W] = x;
    w[Y_LSB +: COORD_W] = y;
    w[Z_LSB +: COORD_W] = z;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO buffering packed ZBT0 words between sample intake and write slots.
// Latency: a word pushed at cycle N is visible at rd_dat in cycle N+1.
// Backpressure: push is ignored while full, pop is ignored while empty; callers gate with full/empty.
//
// Ports: clk, reset_n (async, active-low); wr_vld/wr_dat push side; rd_rdy pops the head,
//        rd_dat is the current head; full/empty status flags.
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the index bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_vld && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_rdy && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: contents are only observable through the pointers.
  always_ff @(posedge clk) begin
    if (wr_vld && !full) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/point_writer.sv
// Purpose: pack (x,y,z) samples into ZBT0 words and write one frame to consecutive addresses.
// Latency: a sample accepted at cycle N into an empty FIFO is written at N+1 at the earliest.
// Backpressure: point_ready drops when the FIFO is full or MAX_POINTS samples were taken this frame.
//
// Ports: clk, reset_n (async, active-low); frame_start/frame_end frame bracket pulses;
//        point_valid/point_ready/point_x/y/z sample intake; wr_grant arbiter slot;
//        zbt0_write_addr/data/we write port; point_count, frame_done, overflow status.
// Build option: define POINT_WRITER_TERMINATOR_EN to append a terminator word after each frame.
module point_writer
  import scanner_pkg::*;
#(
  parameter logic [ZBT_AW-1:0] BASE_ADDR  = 19'd0,
  parameter logic [ZBT_AW-1:0] MAX_POINTS = 19'd16384,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               point_valid,
  output logic               point_ready,
  input  logic [COORD_W-1:0] point_x,
  input  logic [COORD_W-1:0] point_y,
  input  logic [COORD_W-1:0] point_z,
  input  logic               wr_grant,
  output logic [ZBT_AW-1:0]  zbt0_write_addr,
  output logic [ZBT_DW-1:0]  zbt0_write_data,
  output logic               zbt0_we,
  output logic [ZBT_AW-1:0]  point_count,
  output logic               frame_done,
  output logic               overflow
);

  pw_state_t         state, state_nxt;
  logic [ZBT_AW-1:0] wr_ptr;
  logic [ZBT_AW-1:0] acc_cnt;      // samples accepted this frame (written + still buffered)
  logic              data_wr;
  logic              term_wr;
  logic              fifo_full, fifo_empty;
  logic [ZBT_DW-1:0] fifo_head;
  logic              push;

  assign push = point_valid && point_ready;

  sync_fifo #(
    .WIDTH (ZBT_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (push),
    .wr_dat  (pack_point(point_x, point_y, point_z)),
    .rd_rdy  (data_wr),
    .rd_dat  (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt   = state;
    point_ready = 1'b0;
    data_wr     = 1'b0;
    term_wr     = 1'b0;
    frame_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        point_ready = !fifo_full && (acc_cnt < MAX_POINTS);
        data_wr     = !fifo_empty && wr_grant;
        if (frame_end) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        data_wr = !fifo_empty && wr_grant;
        if (fifo_empty) begin
`ifdef POINT_WRITER_TERMINATOR_EN
          // The terminator waits for its own grant; it needs no FIFO entry, so
          // it always has a slot even when the frame hit MAX_POINTS.
          term_wr = wr_grant;
          if (wr_grant) state_nxt = ST_DONE;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address and data are forced to zero outside write cycles so the bus is quiet between writes.
  assign zbt0_we         = data_wr || term_wr;
  assign zbt0_write_addr = zbt0_we ? wr_ptr : '0;
  assign zbt0_write_data = data_wr ? fifo_head : (term_wr ? TERMINATOR : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      acc_cnt     <= '0;
      point_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && frame_start) begin
        wr_ptr      <= BASE_ADDR;
        acc_cnt     <= '0;
        point_count <= '0;
        overflow    <= 1'b0;
      end else begin
        if (push) acc_cnt <= acc_cnt + 19'd1;
        if (data_wr) begin
          wr_ptr      <= wr_ptr + 19'd1;
          point_count <= point_count + 19'd1;
        end else if (term_wr) begin
          wr_ptr <= wr_ptr + 19'd1;
        end
        // A sample offered after the frame limit was reached is lost.
        if (state == ST_FILL && point_valid && acc_cnt >= MAX_POINTS) overflow <= 1'b1;
      end
    end
  end

  // The last data address must stay inside the 19-bit ZBT0 space.
  always_ff @(posedge clk) begin
    assert ({1'b0, BASE_ADDR} + {1'b0, MAX_POINTS} <= 20'h80000)
      else $error("point_writer: BASE_ADDR + MAX_POINTS exceeds the 19-bit address space");
  end

endmodule

// File: tb/tb_point_writer.sv
module tb_point_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fs [2], fe [2], pv [2], gr [2];
  logic [9:0]  px [2], py [2], pz [2];
  logic        pr [2], we [2], fd [2], ov [2];
  logic [18:0] wa [2], pc [2];
  logic [35:0] wd [2];

  always #5 clk = ~clk;

  point_writer u0 (
    .clk(clk), .reset_n(reset_n), .frame_start(fs[0]), .frame_end(fe[0]),
    .point_valid(pv[0]), .point_ready(pr[0]), .point_x(px[0]), .point_y(py[0]), .point_z(pz[0]),
    .wr_grant(gr[0]), .zbt0_write_addr(wa[0]), .zbt0_write_data(wd[0]), .zbt0_we(we[0]),
    .point_count(pc[0]), .frame_done(fd[0]), .overflow(ov[0])
  );

  point_writer #(.MAX_POINTS(19'd5)) u1 (
    .clk(clk), .reset_n(reset_n), .frame_start(fs[1]), .frame_end(fe[1]),
    .point_valid(pv[1]), .point_ready(pr[1]), .point_x(px[1]), .point_y(py[1]), .point_z(pz[1]),
    .wr_grant(gr[1]), .zbt0_write_addr(wa[1]), .zbt0_write_data(wd[1]), .zbt0_we(we[1]),
    .point_count(pc[1]), .frame_done(fd[1]), .overflow(ov[1])
  );

`ifdef POINT_WRITER_TERMINATOR_EN
  localparam int TERM_EXP = 1;
`else
  localparam int TERM_EXP = 0;
`endif

  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  logic [35:0] acc_q [2][$];
  int          acc_c [2][$];
  int          wcnt [2], tcnt [2], fdcnt [2], acc_tot [2], gpct [2];
  bit          last_acc [2];
  logic [35:0] first_wd [2];

  function automatic int maxp(input int k);
    return (k == 0) ? 16384 : 5;
  endfunction

  // Reference packing: x occupies weights 2^20.., y 2^10.., z 2^0..
  function automatic logic [35:0] pack(input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
    return 36'(x) * 36'd1048576 + 36'(y) * 36'd1024 + 36'(z);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe the cycle at the falling edge, then return just after the rising edge.
  task automatic step();
    int c;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      last_acc[k] = 1'b0;
      if (we[k] === 1'b1) begin
        chk("we_needs_grant", 64'(gr[k]), 64'd1);
        if (acc_q[k].size() > 0) begin
          if (wcnt[k] == 0) first_wd[k] = wd[k];
          chk("wr_addr", 64'(wa[k]), 64'(wcnt[k]));
          chk("wr_data", 64'(wd[k]), 64'(acc_q[k].pop_front()));
          c = acc_c[k].pop_front();
          chk("wr_latency", 64'(cyc > c), 64'd1);
          wcnt[k]++;
          chk("wr_within_max", 64'(wcnt[k] <= maxp(k)), 64'd1);
        end else if (TERM_EXP == 1) begin
          chk("term_addr", 64'(wa[k]), 64'(wcnt[k]));
          chk("term_data", 64'(wd[k]), 64'h8_0000_0000);
          tcnt[k]++;
        end else begin
          chk("spurious_write", 64'(we[k]), 64'd0);
        end
      end
      if (acc_tot[k] >= maxp(k)) chk("ready_low_at_max", 64'(pr[k]), 64'd0);
      if (fd[k] === 1'b1) fdcnt[k]++;
      if (pv[k] === 1'b1 && pr[k] === 1'b1) begin
        acc_q[k].push_back(pack(px[k], py[k], pz[k]));
        acc_c[k].push_back(cyc);
        last_acc[k] = 1'b1;
        acc_tot[k]++;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) gr[k] = ($urandom_range(0, 99) < gpct[k]);
  endtask

  task automatic clear_model(input int k);
    acc_q[k].delete();
    acc_c[k].delete();
    wcnt[k] = 0; tcnt[k] = 0; fdcnt[k] = 0; acc_tot[k] = 0;
  endtask

  task automatic begin_frame(input int k);
    clear_model(k);
    fs[k] = 1'b1;
    step();
    fs[k] = 1'b0;
  endtask

  task automatic offer(input int k, input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
    px[k] = x; py[k] = y; pz[k] = z; pv[k] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_acc[k]) break;
    end
    pv[k] = 1'b0;
  endtask

  // Raise frame_end in the very cycle the final sample is accepted.
  task automatic offer_with_end(input int k, input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
    for (int i = 0; i < 40; i++) begin
      if (pr[k] === 1'b1) break;
      step();
    end
    chk("ready_before_end", 64'(pr[k]), 64'd1);
    px[k] = x; py[k] = y; pz[k] = z; pv[k] = 1'b1; fe[k] = 1'b1;
    step();
    pv[k] = 1'b0; fe[k] = 1'b0;
    chk("end_point_taken", 64'(last_acc[k]), 64'd1);
  endtask

  task automatic end_frame(input int k);
    fe[k] = 1'b1;
    step();
    fe[k] = 1'b0;
  endtask

  task automatic finish_frame(input int k, input int exp_n, input logic exp_ov);
    if (gpct[k] < 30) gpct[k] = 30;
    for (int i = 0; i < 400; i++) begin
      if (fdcnt[k] > 0) break;
      step();
    end
    chk("frame_done_seen", 64'(fdcnt[k] > 0), 64'd1);
    step(); step(); step();
    chk("frame_done_once", 64'(fdcnt[k]), 64'd1);
    chk("words_written", 64'(wcnt[k]), 64'(exp_n));
    chk("fifo_drained", 64'(acc_q[k].size()), 64'd0);
    chk("terminators", 64'(tcnt[k]), 64'(TERM_EXP));
    chk("point_count", 64'(pc[k]), 64'(exp_n));
    chk("overflow", 64'(ov[k]), 64'(exp_ov));
  endtask

  initial begin
    int n, k, ne;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fs[i] = 0; fe[i] = 0; pv[i] = 0; gr[i] = 0; px[i] = 0; py[i] = 0; pz[i] = 0;
      gpct[i] = 0; first_wd[i] = '0;
      clear_model(i);
    end
    step(); step();
    chk("rst_ready", 64'(pr[0]), 64'd0);
    chk("rst_we", 64'(we[0]), 64'd0);
    chk("rst_addr", 64'(wa[0]), 64'd0);
    chk("rst_data", 64'(wd[0]), 64'd0);
    chk("rst_count", 64'(pc[0]), 64'd0);
    chk("rst_done", 64'(fd[0]), 64'd0);
    chk("rst_overflow", 64'(ov[0]), 64'd0);
    reset_n = 1'b1;
    step();

    // Three points with a permanent grant.
    gpct[0] = 100; gr[0] = 1'b1;
    begin_frame(0);
    offer(0, 10'd1, 10'd2, 10'd3);
    offer(0, 10'd4, 10'd5, 10'd6);
    offer(0, 10'd7, 10'd8, 10'd9);
    end_frame(0);
    finish_frame(0, 3, 1'b0);
    chk("first_word_layout", 64'(first_wd[0]), 64'h0_0010_0803);

    // No grant: FIFO fills after 4 samples, then drains in order once granted.
    gpct[0] = 0; gr[0] = 1'b0;
    begin_frame(0);
    for (int i = 0; i < 4; i++) offer(0, 10'($urandom), 10'($urandom), 10'($urandom));
    chk("accepted_before_full", 64'(acc_tot[0]), 64'd4);
    px[0] = 10'd33; py[0] = 10'd44; pz[0] = 10'd55; pv[0] = 1'b1;
    step();
    chk("ready_low_when_full", 64'(pr[0]), 64'd0);
    chk("no_accept_when_full", 64'(acc_tot[0]), 64'd4);
    pv[0] = 1'b0;
    gpct[0] = 100;
    offer(0, 10'd33, 10'd44, 10'd55);
    offer(0, 10'($urandom), 10'($urandom), 10'($urandom));
    end_frame(0);
    finish_frame(0, 6, 1'b0);

    // frame_start inside FILL is ignored; frame_end coincides with the last accept.
    gpct[0] = 50;
    begin_frame(0);
    offer(0, 10'($urandom), 10'($urandom), 10'($urandom));
    fs[0] = 1'b1; step(); fs[0] = 1'b0;
    offer(0, 10'($urandom), 10'($urandom), 10'($urandom));
    offer_with_end(0, 10'($urandom), 10'($urandom), 10'($urandom));
    finish_frame(0, 3, 1'b0);

    // Reset in the middle of a frame with two samples buffered.
    gpct[0] = 0; gr[0] = 1'b0;
    begin_frame(0);
    offer(0, 10'd100, 10'd200, 10'd300);
    offer(0, 10'd400, 10'd500, 10'd600);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(pr[0]), 64'd0);
    chk("midrst_we", 64'(we[0]), 64'd0);
    chk("midrst_count", 64'(pc[0]), 64'd0);
    chk("midrst_done", 64'(fd[0]), 64'd0);
    clear_model(0);
    gpct[0] = 100;
    step(); step(); step();
    reset_n = 1'b1;
    step(); step(); step();
    chk("midrst_no_done", 64'(fdcnt[0]), 64'd0);
    chk("midrst_no_write", 64'(wcnt[0] + tcnt[0]), 64'd0);
    begin_frame(0);
    offer(0, 10'($urandom), 10'($urandom), 10'($urandom));
    offer(0, 10'($urandom), 10'($urandom), 10'($urandom));
    end_frame(0);
    finish_frame(0, 2, 1'b0);

    // MAX_POINTS = 5 instance: 8 offered, 5 written, overflow flagged.
    gpct[1] = 100; gr[1] = 1'b1;
    begin_frame(1);
    for (int i = 0; i < 8; i++) offer(1, 10'($urandom), 10'($urandom), 10'($urandom));
    chk("max_accepted", 64'(acc_tot[1]), 64'd5);
    chk("max_ready_low", 64'(pr[1]), 64'd0);
    chk("max_overflow_live", 64'(ov[1]), 64'd1);
    end_frame(1);
    finish_frame(1, 5, 1'b1);

    // Exactly MAX_POINTS with nothing further offered: no overflow.
    begin_frame(1);
    for (int i = 0; i < 5; i++) offer(1, 10'($urandom), 10'($urandom), 10'($urandom));
    end_frame(1);
    finish_frame(1, 5, 1'b0);

    // Randomised frames on both instances with random grant density.
    for (int f = 0; f < 12; f++) begin
      k = f % 2;
      n = $urandom_range(0, 9);
      gpct[k] = $urandom_range(20, 100);
      ne = (n < maxp(k)) ? n : maxp(k);
      begin_frame(k);
      if (n > 0 && n <= maxp(k) && ($urandom_range(0, 2) == 0)) begin
        for (int i = 0; i < n - 1; i++) offer(k, 10'($urandom), 10'($urandom), 10'($urandom));
        offer_with_end(k, 10'($urandom), 10'($urandom), 10'($urandom));
      end else begin
        for (int i = 0; i < n; i++) offer(k, 10'($urandom), 10'($urandom), 10'($urandom));
        end_frame(k);
      end
      finish_frame(k, ne, logic'(n > maxp(k)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
